// File: rtl/piso_tx_if.sv
// Load handshake and serial link of the parallel-in/serial-out transmitter.
// master = parallel source and link monitor, slave = transmitter.
interface piso_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output din, load_valid,
    input  load_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  din, load_valid,
    output load_ready, sout, sout_valid, busy, done
  );
endinterface

// File: rtl/piso_tx.sv
// Serialises one WIDTH-bit word per frame, plus an optional even-parity bit.
// The first bit appears one cycle after accept; load_ready is held low until a frame has ended.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic    clk,
  input  logic    rst,
  piso_tx_if.slave bus
);
  localparam int NBITS = WIDTH + (PARITY_EN ? 1 : 0);
  localparam int CW    = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST      = CW'(NBITS - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  // sout is registered, so the first bit is taken straight from din at the accept
  // edge, and the shift register holds only the bits still to be sent.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    sout_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          state_d = SHIFT;
          cnt_d   = '0;
          par_d   = ^bus.din;
          if (MSB_FIRST) begin
            sout_d  = bus.din[WIDTH-1];
            shreg_d = {bus.din[WIDTH-2:0], 1'b0};
          end else begin
            sout_d  = bus.din[0];
            shreg_d = {1'b0, bus.din[WIDTH-1:1]};
          end
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          shreg_d = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (PARITY_EN && cnt_q == LAST_DATA) begin
            sout_d = par_q;
          end else if (MSB_FIRST) begin
            sout_d  = shreg_q[WIDTH-1];
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          end else begin
            sout_d  = shreg_q[0];
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.load_ready = (state_q == IDLE);
  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.busy       = (state_q == SHIFT);
  assign bus.sout       = sout_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_piso_tx.sv
// Directed bench: MSB-first without parity (u_a) and LSB-first with parity (u_b).
module tb_piso_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lv  = 1'b0;
  logic [7:0] d   = 8'h00;
  bit         cur = 1'b0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(8)) ia ();
  piso_tx_if #(.WIDTH(8)) ib ();

  assign ia.din        = d;
  assign ib.din        = d;
  assign ia.load_valid = lv & ~cur;
  assign ib.load_valid = lv & cur;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_a (.clk(clk), .rst(rst), .bus(ia));
  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) u_b (.clk(clk), .rst(rst), .bus(ib));

  logic o_sout, o_sv, o_busy, o_done, o_rdy;
  always_comb begin
    o_sout = cur ? ib.sout       : ia.sout;
    o_sv   = cur ? ib.sout_valid : ia.sout_valid;
    o_busy = cur ? ib.busy       : ia.busy;
    o_done = cur ? ib.done       : ia.done;
    o_rdy  = cur ? ib.load_ready : ia.load_ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input bit sel, input logic [7:0] word);
    cur = sel;
    d   = word;
    lv  = 1'b1;
    tick();
    lv  = 1'b0;
  endtask

  // seq lists the frame in send order, first bit leftmost; pk >= 0 drives a
  // competing load of 8'hFF for three cycles starting at frame bit pk.
  task automatic run_bits(input string name, input logic [15:0] seq, input int n, input int pk);
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s bit%0d sout", name, k), 32'(o_sout), 32'(seq[n-1-k]));
      check($sformatf("%s bit%0d sout_valid", name, k), 32'(o_sv), 32'd1);
      check($sformatf("%s bit%0d busy", name, k), 32'(o_busy), 32'd1);
      check($sformatf("%s bit%0d load_ready", name, k), 32'(o_rdy), 32'd0);
      check($sformatf("%s bit%0d done", name, k), 32'(o_done), 32'd0);
      if (pk >= 0) begin
        lv = (k >= pk) && (k < pk + 3);
        if (k == pk) d = 8'hFF;
      end
      tick();
    end
    check({name, " end done"}, 32'(o_done), 32'd1);
    check({name, " end sout_valid"}, 32'(o_sv), 32'd0);
    check({name, " end busy"}, 32'(o_busy), 32'd0);
    check({name, " end sout"}, 32'(o_sout), 32'd0);
    check({name, " end load_ready"}, 32'(o_rdy), 32'd1);
  endtask

  task automatic idle_check(input string name);
    tick();
    check({name, " idle done"}, 32'(o_done), 32'd0);
    check({name, " idle sout_valid"}, 32'(o_sv), 32'd0);
    check({name, " idle load_ready"}, 32'(o_rdy), 32'd1);
  endtask

  initial begin
    // Reset with a word offered: nothing may start.
    cur = 1'b0;
    lv  = 1'b1;
    d   = 8'hFF;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rst%0d sout", i), 32'(ia.sout), 32'd0);
      check($sformatf("rst%0d sout_valid", i), 32'(ia.sout_valid), 32'd0);
      check($sformatf("rst%0d busy", i), 32'(ia.busy), 32'd0);
      check($sformatf("rst%0d done", i), 32'(ia.done), 32'd0);
    end
    rst = 1'b0;
    lv  = 1'b0;
    tick();
    check("post-rst a load_ready", 32'(ia.load_ready), 32'd1);
    check("post-rst b load_ready", 32'(ib.load_ready), 32'd1);
    check("post-rst a sout_valid", 32'(ia.sout_valid), 32'd0);

    // Single MSB-first frame.
    accept(1'b0, 8'h1E);
    run_bits("msb 1E", 16'b00011110, 8, -1);
    idle_check("msb 1E");

    // LSB-first with even parity: 07 has three ones -> parity 1.
    accept(1'b1, 8'h07);
    run_bits("lsb 07", 16'b111000001, 9, -1);
    idle_check("lsb 07");

    // Load attempt during the third shift cycle must be ignored.
    accept(1'b0, 8'h1E);
    run_bits("busy 1E", 16'b00011110, 8, 2);
    idle_check("busy 1E");

    // Back-to-back with load_valid held: second accept at edge A+9.
    cur = 1'b0;
    d   = 8'hA5;
    lv  = 1'b1;
    tick();
    d   = 8'h3C;
    run_bits("b2b A5", 16'b10100101, 8, -1);
    tick();
    lv  = 1'b0;
    run_bits("b2b 3C", 16'b00111100, 8, -1);
    idle_check("b2b 3C");

    // Reset after the third bit aborts the frame without done.
    accept(1'b0, 8'h1E);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort bit%0d sout", k), 32'(o_sout), (k == 2) ? 32'd0 : 32'd0);
      check($sformatf("abort bit%0d sout_valid", k), 32'(o_sv), 32'd1);
      if (k < 2) tick();
    end
    rst = 1'b1;
    tick();
    check("abort sout", 32'(ia.sout), 32'd0);
    check("abort sout_valid", 32'(ia.sout_valid), 32'd0);
    check("abort busy", 32'(ia.busy), 32'd0);
    check("abort done", 32'(ia.done), 32'd0);
    rst = 1'b0;
    tick();
    check("abort after done", 32'(ia.done), 32'd0);
    check("abort after load_ready", 32'(ia.load_ready), 32'd1);
    accept(1'b0, 8'h81);
    run_bits("after abort 81", 16'b10000001, 8, -1);
    idle_check("after abort 81");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in, serial-out transmitter with a valid/ready load handshake. It drives the serial bit stream that the team's D flip-flop/latch capture stages sample on the far end.
- It accepts a WIDTH-bit word, then shifts it out one bit per clock, optionally followed by an even-parity bit. It pulses a completion strobe when the frame ends.
- It sits between a parallel data source and a single-wire serial link.

Parameters:
- WIDTH, 8: data word width in bits; minimum 2.
- MSB_FIRST, 1: 1 sends din[WIDTH-1] first; 0 sends din[0] first.
- PARITY_EN, 0: 1 appends one even-parity bit after the data bits (XOR of all data bits).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word; sampled only on a handshake.
- load_valid  input  1  source has a word on din.
- load_ready  output  1  block can accept a word; high only in IDLE.
- sout  output  1  serial data out, registered.
- sout_valid  output  1  high while sout carries a frame bit, registered.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse after the final frame bit.

Behaviour:
- Reset: on a clk edge with rst=1:
  - state goes to IDLE; shift register and bit counter are cleared.
  - sout=0, sout_valid=0, busy=0, done=0; load_ready=1 from the next cycle.
  - rst overrides every other input, including during a frame.
- NBITS = WIDTH + PARITY_EN. The bit counter is clog2(NBITS+1) wide.
- States:
  - IDLE: load_ready=1, sout=0, sout_valid=0, busy=0.
  - SHIFT: load_ready=0, busy=1, sout_valid=1.
- Handshake:
  - A transfer occurs at the edge where load_valid=1 and load_ready=1.
  - din is captured at that edge, the parity bit is computed from the captured din, the counter is set to 0, and state goes to SHIFT.
  - load_valid while load_ready=0 is ignored: no capture, no side effects. din may change freely outside the handshake edge.
- Timing, with the accept edge called edge A:
  - After edge A+k, for k=0..NBITS-1, sout holds frame bit k. The data bits go in MSB_FIRST order, and the parity bit (if enabled) is frame bit WIDTH.
  - At edge A+NBITS: state goes to IDLE, sout=0, sout_valid=0, busy=0, and done=1 for exactly that one cycle.
  - The earliest next accept is edge A+NBITS+1, which gives one idle cycle between back-to-back frames.
- Shifting:
  - MSB_FIRST=1: the shift register shifts left and sout takes the MSB.
  - MSB_FIRST=0: the shift register shifts right and sout takes the LSB.
  - Vacated bits fill with 0. The parity bit is loaded after the last data bit.
- Reset mid-frame: the frame is aborted immediately and no done pulse is issued. Bits already sent are not retransmitted.
- done never coincides with sout_valid=1. busy equals sout_valid at all times.

Test Plan:
- Reset check: rst=1 for 2 cycles with load_valid=1 and din=8'hFF, then rst=0 -> while rst=1: sout=0, sout_valid=0, busy=0, done=0. load_ready=1 on the first cycle after release. No frame starts during reset.
- Single frame, MSB_FIRST=1, din=8'h1E accepted at edge A -> sout = 0,0,0,1,1,1,1,0 after edges A..A+7. sout_valid=1 for exactly 8 cycles. done=1 only after edge A+8.
- LSB-first with parity, MSB_FIRST=0, PARITY_EN=1, din=8'h07 -> sout = 1,1,1,0,0,0,0,0 then parity bit 1. sout_valid=1 for 9 cycles. done after edge A+9.
- Load while busy: accept 8'h1E, then drive load_valid=1 with din=8'hFF during the 3rd shift cycle -> stream unchanged (0,0,0,1,1,1,1,0). load_ready=0 throughout SHIFT. No second capture until IDLE.
- Back-to-back: load_valid held at 1 with din 8'hA5 then 8'h3C -> second accept at edge A+9. Exactly one sout_valid=0 cycle (done=1) between the frames. Second stream is 0,0,1,1,1,1,0,0.
- Mid-frame reset: rst=1 after the 3rd bit of 8'h1E -> next cycle sout=0, sout_valid=0, busy=0, done stays 0. A new frame 8'h81 is then sent correctly as 1,0,0,0,0,0,0,1.
